// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pulls one word per frame from an upstream FIFO and shifts it out LSB first.
// Optional even-parity bit between data and stop is built when UART_TX_PARITY_EN is defined.
module uart_tx_ser #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tx_en,
    input  logic                  i_fifo_empty,
    output logic                  o_pop,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_txd,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd5
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ready_q;
    logic                  baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign baud_tick = (baud_q == BAUD_LAST);

    // State and datapath registers; reset parks the line high and drops any fetched word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state, counters and pop strobe; line/busy/done are precomputed from the next state.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_tick ? '0 : baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        o_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (ready_q && i_tx_en && !i_fifo_empty) begin
                    o_pop   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                baud_d   = '0;
                bit_d    = '0;
                shift_d  = i_rdata;
                state_d  = START;
`ifdef UART_TX_PARITY_EN
                parity_d = ^i_rdata;
`endif
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    end

    assign o_txd  = txd_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
